kettle_ctrl_v2: RTL and testbench

Parametrised successor kettle controller FSM. It adds a programmable target temperature, a keep-warm hold phase with hysteresis, a heating timeout watchdog, and multi-sample debouncing of the water-level input. Sits between the user panel (start/cancel buttons, setpoint) and the heater driver and indicator/fault logic.

---
 rtl/kettle_ctrl_v2.sv | 173 +++++++++++++++++
 tb/tb_kettle_ctrl_v2.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/kettle_ctrl_v2.sv
// Kettle controller: programmable setpoint, keep-warm hysteresis, heating watchdog, debounced water level.
// Optional KETTLE_BOIL_DRY_EN adds a dry-boil detector (fast temperature rise while heating).
module kettle_ctrl_v2 #(
    parameter int TEMP_W      = 8,
    parameter int MAX_TEMP    = 110,
    parameter int HYST        = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int WARM_CYC    = 500,
    parameter int DEB_N       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_button,
    input  logic              cancel_button,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [TEMP_W-1:0] temperature_sensor,
    input  logic              water_level_sensor,
    output logic              heater,
    output logic              indicator,
    output logic              shutdown,
    output logic [1:0]        fault_code,
    output logic [2:0]        state_out
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HEAT  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_WARM  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int WCNT_W = $clog2(WARM_CYC + 1);
    localparam int DCNT_W = $clog2(DEB_N + 1);

    localparam logic [TEMP_W-1:0] LP_MAX   = TEMP_W'(MAX_TEMP);
    localparam logic [TEMP_W-1:0] LP_SPMAX = TEMP_W'(MAX_TEMP - 1);
    localparam logic [TEMP_W-1:0] LP_FEXIT = TEMP_W'(MAX_TEMP - HYST);
    localparam logic [TEMP_W:0]   LP_HYST  = (TEMP_W+1)'(HYST);

    logic [2:0]        r_state, w_next;
    logic [1:0]        r_fault, w_fault;
    logic [TEMP_W-1:0] r_sp_lat;
    logic [TCNT_W-1:0] r_tcnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_wl_ok;
    logic [DCNT_W-1:0] r_deb_cnt;

    logic              w_below_max, w_tmo, w_wdone, w_warm_heat, w_dry, w_start_heat;
    logic [TEMP_W-1:0] w_sp_eff;

    assign w_below_max  = temperature_sensor < LP_MAX;
    assign w_tmo        = r_tcnt == TCNT_W'(TIMEOUT_CYC - 1);
    assign w_wdone      = r_wcnt == WCNT_W'(WARM_CYC - 1);
    assign w_sp_eff     = (setpoint > LP_SPMAX) ? LP_SPMAX : setpoint;
    // Sum is one bit wider so temp near full scale cannot wrap and re-enable the heater.
    assign w_warm_heat  = ({1'b0, temperature_sensor} + LP_HYST) <= {1'b0, r_sp_lat};
    assign w_start_heat = (r_state == S_IDLE) && (w_next == S_HEAT);

`ifdef KETTLE_BOIL_DRY_EN
    logic [TEMP_W-1:0] r_dly [8];
    logic [3:0]        r_dly_cnt;

    // r_dly[7] is the temperature 8 cycles ago; only trusted once 8 HEATING samples exist.
    assign w_dry = (r_dly_cnt == 4'd8) &&
                   ({1'b0, temperature_sensor} >= ({1'b0, r_dly[7]} + (TEMP_W+1)'(16)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_dly[i] <= '0;
            r_dly_cnt <= '0;
        end else begin
            r_dly[0] <= temperature_sensor;
            for (int i = 1; i < 8; i++) r_dly[i] <= r_dly[i-1];
            if (w_start_heat || r_state != S_HEAT) r_dly_cnt <= '0;
            else if (r_dly_cnt != 4'd8)            r_dly_cnt <= r_dly_cnt + 4'd1;
        end
    end
`else
    assign w_dry = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wl_ok   <= 1'b0;
            r_deb_cnt <= '0;
        end else if (water_level_sensor == r_wl_ok) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DCNT_W'(DEB_N - 1)) begin
            r_wl_ok   <= water_level_sensor;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fault <= 2'd0;
        end else begin
            r_state <= w_next;
            r_fault <= w_fault;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_fault = r_fault;
        case (r_state)
            S_IDLE: begin
                w_fault = 2'd0;
                if (start_button && r_wl_ok && w_below_max) w_next = S_HEAT;
            end
            S_HEAT: begin
                if (!w_below_max)           begin w_next = S_FAULT; w_fault = 2'd1; end
                else if (!r_wl_ok || w_dry) begin w_next = S_FAULT; w_fault = 2'd2; end
                else if (w_tmo)             begin w_next = S_FAULT; w_fault = 2'd3; end
                else if (cancel_button)     w_next = S_IDLE;
                else if (temperature_sensor >= r_sp_lat) w_next = S_READY;
            end
            S_READY: w_next = cancel_button ? S_IDLE : S_WARM;
            S_WARM: begin
                if (!w_below_max)                 begin w_next = S_FAULT; w_fault = 2'd1; end
                else if (!r_wl_ok)                begin w_next = S_FAULT; w_fault = 2'd2; end
                else if (cancel_button || w_wdone) w_next = S_IDLE;
            end
            S_FAULT: begin
                if (!start_button && cancel_button && (temperature_sensor < LP_FEXIT) && r_wl_ok) begin
                    w_next  = S_IDLE;
                    w_fault = 2'd0;
                end
            end
            default: begin
                w_next  = S_IDLE;
                w_fault = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp_lat <= '0;
            r_tcnt   <= '0;
            r_wcnt   <= '0;
        end else begin
            if (w_start_heat) begin
                r_sp_lat <= w_sp_eff;
                r_tcnt   <= '0;
            end else if (r_state == S_HEAT) begin
                r_tcnt <= r_tcnt + TCNT_W'(1);
            end
            if (r_state == S_READY)     r_wcnt <= '0;
            else if (r_state == S_WARM) r_wcnt <= r_wcnt + WCNT_W'(1);
        end
    end

    always_comb begin
        heater     = 1'b0;
        indicator  = 1'b0;
        shutdown   = 1'b0;
        fault_code = r_fault;
        state_out  = r_state;
        case (r_state)
            S_HEAT:  heater = 1'b1;
            S_READY: indicator = 1'b1;
            S_WARM: begin
                indicator = 1'b1;
                heater    = w_warm_heat;
            end
            S_FAULT: shutdown = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_kettle_ctrl_v2.sv
// Directed bench for kettle_ctrl_v2 with default parameters and hand-computed expectations.
module tb_kettle_ctrl_v2;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_button, cancel_button, water_level_sensor;
    logic [7:0] setpoint, temperature_sensor;
    logic       heater, indicator, shutdown;
    logic [1:0] fault_code;
    logic [2:0] state_out;

    int n_chk  = 0;
    int n_pass = 0;

    kettle_ctrl_v2 dut (
        .clk                (clk),
        .rst                (rst),
        .start_button       (start_button),
        .cancel_button      (cancel_button),
        .setpoint           (setpoint),
        .temperature_sensor (temperature_sensor),
        .water_level_sensor (water_level_sensor),
        .heater             (heater),
        .indicator          (indicator),
        .shutdown           (shutdown),
        .fault_code         (fault_code),
        .state_out          (state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges and land 2 time units after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_button = 1'b0; cancel_button = 1'b0;
        water_level_sensor = 1'b0; setpoint = 8'd90; temperature_sensor = 8'd20;
        #12;
        chk("rst_state", state_out, 0);
        chk("rst_heater", heater, 0);
        chk("rst_ind", indicator, 0);
        chk("rst_shut", shutdown, 0);
        chk("rst_fault", fault_code, 0);
        #10;
        rst = 1'b0; water_level_sensor = 1'b1; start_button = 1'b1;

        // Debounce: wl_ok rises on the 3rd edge, HEATING on the 4th
        step(2); chk("deb2_idle", state_out, 0);
        step(1); chk("deb3_idle", state_out, 0);
        step(1); chk("heat_state", state_out, 1);
        chk("heat_heater", heater, 1);
        start_button = 1'b0;

        for (int t = 20; t < 90; t += 10) begin
            temperature_sensor = 8'(t);
            step(1);
            chk("ramp_state", state_out, 1);
            chk("ramp_heater", heater, 1);
        end
        temperature_sensor = 8'd90;
        step(1);
        chk("ready_state", state_out, 2);
        chk("ready_ind", indicator, 1);
        chk("ready_heater", heater, 0);
        step(1);
        chk("warm_state", state_out, 3);
        chk("warm_ind", indicator, 1);
        chk("warm_h90", heater, 0);
        temperature_sensor = 8'd86; #1;
        chk("warm_h86", heater, 1);
        temperature_sensor = 8'd87; #1;
        chk("warm_h87", heater, 0);
        step(499); chk("warm_499", state_out, 3);
        step(1);   chk("warm_exit", state_out, 0);
        chk("idle_ind", indicator, 0);

        // Overheat beats cancel; exit needs cancel with temp < 106
        temperature_sensor = 8'd50; start_button = 1'b1;
        step(1); chk("h2_state", state_out, 1);
        start_button = 1'b0; temperature_sensor = 8'd110; cancel_button = 1'b1;
        step(1);
        chk("ovh_state", state_out, 4);
        chk("ovh_code", fault_code, 1);
        chk("ovh_shut", shutdown, 1);
        chk("ovh_heater", heater, 0);
        step(1); chk("ovh_hot_hold", state_out, 4);
        temperature_sensor = 8'd100; cancel_button = 1'b0;
        step(1); chk("ovh_nocancel", state_out, 4);
        chk("ovh_code_held", fault_code, 1);
        cancel_button = 1'b1;
        step(1);
        chk("ovh_exit", state_out, 0);
        chk("ovh_code_clr", fault_code, 0);
        chk("ovh_shut_clr", shutdown, 0);

        // Plain cancel from HEATING
        cancel_button = 1'b0; temperature_sensor = 8'd50; start_button = 1'b1;
        step(1); chk("h3_state", state_out, 1);
        start_button = 1'b0; cancel_button = 1'b1;
        step(1); chk("cancel_idle", state_out, 0);
        cancel_button = 1'b0;

        // Water-level glitch of 2 cycles ignored, 3 cycles faults
        start_button = 1'b1;
        step(1); chk("h4_state", state_out, 1);
        start_button = 1'b0; water_level_sensor = 1'b0;
        step(2); water_level_sensor = 1'b1;
        step(1); chk("glitch2_ok", state_out, 1);
        water_level_sensor = 1'b0;
        step(3); chk("low3_still", state_out, 1);
        step(1);
        chk("low_state", state_out, 4);
        chk("low_code", fault_code, 2);
        water_level_sensor = 1'b1; cancel_button = 1'b1;
        step(3); chk("low_wait_deb", state_out, 4);
        step(1); chk("low_exit", state_out, 0);
        cancel_button = 1'b0;

        // Timeout: FAULT exactly 1000 cycles after entering HEATING
        start_button = 1'b1;
        step(1); chk("h5_state", state_out, 1);
        start_button = 1'b0;
        step(999); chk("tmo_999", state_out, 1);
        step(1);
        chk("tmo_state", state_out, 4);
        chk("tmo_code", fault_code, 3);
        cancel_button = 1'b1;
        step(1); chk("tmo_exit", state_out, 0);
        cancel_button = 1'b0;

        // Clamp to 109, then async reset mid-HEATING
        setpoint = 8'd200; temperature_sensor = 8'd108; start_button = 1'b1;
        step(1); chk("h6_state", state_out, 1);
        start_button = 1'b0;
        step(3); chk("clamp_108", state_out, 1);
        rst = 1'b1; #1;
        chk("arst_heater", heater, 0);
        chk("arst_state", state_out, 0);
        #1 rst = 1'b0;
        step(3);
        start_button = 1'b1;
        step(1); chk("h7_state", state_out, 1);
        start_button = 1'b0; temperature_sensor = 8'd109;
        step(1); chk("clamp_109", state_out, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
